udp_tx_byte_pack: RTL
=====================

# udp_tx_byte_pack

Byte-to-word transmit packer for the UDP path. It accepts a byte-wide frame stream from command/response logic and packs it big-endian into 32-bit words (first byte in bits [31:24]). It buffers one frame, then hands the frame to the UDP stack with a request/acknowledge handshake, the configured destination port and the byte length, followed by the data words under ready backpressure.

## Interface
- FIFO_AW, 7: word-buffer address width; depth 2^FIFO_AW words.
- MAX_LEN, 512: maximum frame length in bytes. Must satisfy MAX_LEN <= 4*2^FIFO_AW.

- Clk  in  1  clock.
- Rst  in  1  reset, asynchronous, active-high.
- cfg_udp_dstport  in  16  destination port, sampled at frame start.
- udp_snd_valid  in  1  frame gate; every cycle high carries one byte; frame ends when it falls.
- udp_snd_byte  in  8  frame byte.
- udp_snd_busy  out  1  high whenever the block is not IDLE.
- udp_tx_req  out  1  transmit request to UDP stack.
- udp_tx_ack  in  1  stack accepts the request.
- udp_tx_dst_port  out  16  latched destination port; stable from req until frame end.
- udp_tx_data_len  out  16  frame length in bytes; stable from req until frame end.
- udp_tx_data  out  32  packed data word.
- udp_tx_data_en  out  1  data word valid.
- udp_tx_ready  in  1  stack accepts the word when data_en & ready.
- frame_drop_cnt  out  16  saturating count of rejected frames.

## Operation
- States: IDLE, FILL, FLUSH, REQ, SEND.
- Frame start is the rising edge of valid (valid & ~valid_d1).
  - Start in IDLE: enter FILL, latch cfg_udp_dstport, accept the first byte.
  - Start in any other state: the whole frame is ignored, its bytes are not stored, and frame_drop_cnt increments by 1, saturating at 0xFFFF.
- FILL: byte k goes to word k>>2, lane k[1:0]; lane 0 = [31:24], lane 3 = [7:0]. A complete word is written to the FIFO in the cycle after its 4th byte. Byte count increments per accepted byte.
- Bytes beyond MAX_LEN are discarded and the count clamps at MAX_LEN.
- FILL → FLUSH when valid is low. FLUSH writes any partial word with the unused low lanes zero, then → REQ.
- REQ: udp_tx_req = 1 until udp_tx_ack is sampled high, then → SEND.
- SEND: present FIFO words in order. words = (len+3)>>2. Advance only on data_en & ready; data and data_en hold while ready = 0.
  - After the last word is accepted → IDLE, and the byte counter and lane index clear.
- Reset values: every output 0; FIFO empty; state IDLE; counters 0.
- Reset mid-frame or mid-SEND aborts: no further req or data_en; the partial frame is lost.

## Timing
- Bytes b0..bN-1 arrive in cycles 0..N-1; valid is low in cycle N. FLUSH is in cycle N+1.
- udp_tx_req is first high in cycle N+2, with len and dst_port already valid.
- The ack cycle is the last req cycle. udp_tx_data_en rises the next cycle with word 0.
- With ready held high, one word transfers per cycle with no bubbles. data_en falls the cycle after the last accepted word.
- udp_snd_busy is high from cycle 0 until the cycle after the last word transfer. The next frame may start the cycle busy is low.
- A frame whose rising edge coincides with the last word transfer is dropped.

## Test plan
- Port 0x1F90, bytes 11 22 33 44 → req with len 4 and port 0x1F90; one word 0x11223344; busy low afterwards.
- Bytes 11 22 33 44 55 → len 5; words 0x11223344 then 0x55000000.
- 12-byte frame, ready toggling 1,0,0,1,0,1 → three words in order; each word held stable while ready = 0; exactly 3 transfers.
- Second frame starts during REQ with ack delayed 10 cycles → first frame sent intact; frame_drop_cnt = 1; no bytes from the second frame appear.
- 515-byte frame with default parameters → len 512; 128 words; last word formed from bytes 508–511.
- Rst pulsed in the middle of SEND → all outputs 0 immediately. A following 4-byte frame transmits correctly with len 4.

Source files
------------

// File: rtl/udp_tx_byte_pack.sv
// Byte-to-word transmit packer: buffers one byte-wide frame as big-endian 32-bit words,
// then hands it to the UDP stack with a req/ack handshake and ready-backpressured words.
module udp_tx_byte_pack #(
  parameter int FIFO_AW = 7,
  parameter int MAX_LEN = 512
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] cfg_udp_dstport,
  input  logic        udp_snd_valid,
  input  logic [7:0]  udp_snd_byte,
  output logic        udp_snd_busy,
  output logic        udp_tx_req,
  input  logic        udp_tx_ack,
  output logic [15:0] udp_tx_dst_port,
  output logic [15:0] udp_tx_data_len,
  output logic [31:0] udp_tx_data,
  output logic        udp_tx_data_en,
  input  logic        udp_tx_ready,
  output logic [15:0] frame_drop_cnt
);

  localparam int          DEPTH     = 1 << FIFO_AW;
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    FLUSH = 3'd2,
    REQ   = 3'd3,
    SEND  = 3'd4
  } state_t;

  state_t             state;
  logic               valid_d1;
  logic [15:0]        byte_cnt;
  logic [31:0]        word_acc;
  logic               word_full;
  logic [FIFO_AW-1:0] pend_addr;
  logic [15:0]        port_lat;
  logic [FIFO_AW-1:0] rd_addr;
  logic [FIFO_AW-1:0] rd_addr_next;
  logic [15:0]        word_last;
  logic               frame_start;
  logic               wr_en;
  logic [FIFO_AW-1:0] wr_addr;
  logic [31:0]        mem [DEPTH];

  assign frame_start  = udp_snd_valid & ~valid_d1;
  assign udp_snd_busy = (state != IDLE) | frame_start;
  assign rd_addr_next = rd_addr + {{(FIFO_AW-1){1'b0}}, 1'b1};
  assign word_last    = ((udp_tx_data_len + 16'd3) >> 2) - 16'd1;

  // Buffer write select: a completed word the cycle after its 4th byte, or the partial tail in FLUSH.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = pend_addr;
    if (word_full) begin
      wr_en   = 1'b1;
      wr_addr = pend_addr;
    end else if ((state == FLUSH) && (byte_cnt[1:0] != 2'd0)) begin
      wr_en   = 1'b1;
      wr_addr = byte_cnt[FIFO_AW+1:2];
    end else begin
      wr_en   = 1'b0;
      wr_addr = pend_addr;
    end
  end

  // Frame buffer write port; contents are only ever read below the stored word count.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= word_acc;
    end
  end

  // Control FSM with registered handshake and data outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state           <= IDLE;
      valid_d1        <= 1'b0;
      byte_cnt        <= 16'd0;
      word_acc        <= 32'd0;
      word_full       <= 1'b0;
      pend_addr       <= '0;
      port_lat        <= 16'd0;
      rd_addr         <= '0;
      udp_tx_req      <= 1'b0;
      udp_tx_dst_port <= 16'd0;
      udp_tx_data_len <= 16'd0;
      udp_tx_data     <= 32'd0;
      udp_tx_data_en  <= 1'b0;
      frame_drop_cnt  <= 16'd0;
    end else begin
      valid_d1  <= udp_snd_valid;
      word_full <= 1'b0;

      // A frame starting while a previous one is still in flight is rejected whole.
      if (frame_start && (state != IDLE) && (frame_drop_cnt != 16'hFFFF)) begin
        frame_drop_cnt <= frame_drop_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (frame_start) begin
            state    <= FILL;
            port_lat <= cfg_udp_dstport;
            byte_cnt <= 16'd1;
            word_acc <= {udp_snd_byte, 24'h000000};
          end
        end

        FILL: begin
          if (!udp_snd_valid) begin
            state <= FLUSH;
          end else if (byte_cnt < MAX_LEN_W) begin
            byte_cnt <= byte_cnt + 16'd1;
            case (byte_cnt[1:0])
              2'd0:    word_acc        <= {udp_snd_byte, 24'h000000};
              2'd1:    word_acc[23:16] <= udp_snd_byte;
              2'd2:    word_acc[15:8]  <= udp_snd_byte;
              2'd3:    word_acc[7:0]   <= udp_snd_byte;
              default: word_acc        <= word_acc;
            endcase
            if (byte_cnt[1:0] == 2'd3) begin
              word_full <= 1'b1;
              pend_addr <= byte_cnt[FIFO_AW+1:2];
            end
          end
        end

        FLUSH: begin
          state           <= REQ;
          udp_tx_req      <= 1'b1;
          udp_tx_dst_port <= port_lat;
          udp_tx_data_len <= byte_cnt;
        end

        REQ: begin
          if (udp_tx_ack) begin
            state          <= SEND;
            udp_tx_req     <= 1'b0;
            udp_tx_data_en <= 1'b1;
            udp_tx_data    <= mem[{FIFO_AW{1'b0}}];
            rd_addr        <= '0;
          end
        end

        SEND: begin
          if (udp_tx_data_en && udp_tx_ready) begin
            if (16'(rd_addr) == word_last) begin
              state           <= IDLE;
              udp_tx_data_en  <= 1'b0;
              udp_tx_data     <= 32'd0;
              udp_tx_dst_port <= 16'd0;
              udp_tx_data_len <= 16'd0;
              byte_cnt        <= 16'd0;
              rd_addr         <= '0;
            end else begin
              rd_addr     <= rd_addr_next;
              udp_tx_data <= mem[rd_addr_next];
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
